// File: rtl/mem_ctlr.sv
// mem_ctlr: arbitrates dcache/icache onto one memory port and steers returning tags to their owner.
// Define MEM_CTLR_RR_EN for round-robin arbitration; otherwise dcache has fixed priority.
`ifndef XLEN
`define XLEN 32
`endif
module mem_ctlr #(
  parameter int TAG_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        dcache2ctlr_command,
  input  logic [`XLEN-1:0]  dcache2ctlr_addr,
  input  logic [63:0]       dcache2ctlr_data,
  input  logic [1:0]        icache2ctlr_command,
  input  logic [`XLEN-1:0]  icache2ctlr_addr,
  output logic [1:0]        proc2mem_command,
  output logic [`XLEN-1:0]  proc2mem_addr,
  output logic [63:0]       proc2mem_data,
  input  logic [TAG_W-1:0]  mem2proc_response,
  input  logic [63:0]       mem2proc_data,
  input  logic [TAG_W-1:0]  mem2proc_tag,
  output logic [TAG_W-1:0]  Ctlr2proc_response,
  output logic [63:0]       Ctlr2proc_data,
  output logic [TAG_W-1:0]  Ctlr2proc_tag,
  output logic [TAG_W-1:0]  Ctlr2icache_response,
  output logic [63:0]       Ctlr2icache_data,
  output logic [TAG_W-1:0]  Ctlr2icache_tag,
  output logic [TAG_W-1:0]  dcache_outstanding,
  output logic [TAG_W-1:0]  icache_outstanding,
  output logic              ctlr_err
);
  localparam int N = 1 << TAG_W;
  localparam logic [1:0] BUS_NONE = 2'd0;
  logic d_req, i_req, gnt, gnt_i, alloc, hit, own, same, ovr;
  logic [N-1:0] valid_q, valid_d, owner_q, owner_d;
  logic [TAG_W-1:0] d_cnt_q, d_cnt_d, i_cnt_q, i_cnt_d;
  logic err_q, err_d;
  assign d_req = dcache2ctlr_command != BUS_NONE;
  assign i_req = icache2ctlr_command != BUS_NONE;
  assign gnt = d_req | i_req;
`ifdef MEM_CTLR_RR_EN
  logic ptr_q, ptr_d;
  // ptr_q set means icache was the last accepted requester, so dcache wins the next conflict
  assign gnt_i = i_req & (~d_req | ~ptr_q);
  assign ptr_d = alloc ? gnt_i : ptr_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) ptr_q <= 1'b1;
    else ptr_q <= ptr_d;
`else
  assign gnt_i = i_req & ~d_req;
`endif
  assign proc2mem_command = gnt_i ? icache2ctlr_command : dcache2ctlr_command;
  assign proc2mem_addr = gnt_i ? icache2ctlr_addr : d_req ? dcache2ctlr_addr : '0;
  assign proc2mem_data = (d_req & ~gnt_i) ? dcache2ctlr_data : '0;
  assign Ctlr2proc_response = (d_req & ~gnt_i) ? mem2proc_response : '0;
  assign Ctlr2icache_response = gnt_i ? mem2proc_response : '0;
  assign hit = (mem2proc_tag != '0) & valid_q[mem2proc_tag];
  assign own = owner_q[mem2proc_tag];
  assign alloc = (mem2proc_response != '0) & gnt;
  // a tag returning and re-accepted on the same edge is a legal reuse, not a double accept
  assign same = hit & (mem2proc_tag == mem2proc_response);
  assign ovr = alloc & valid_q[mem2proc_response] & ~same;
  assign Ctlr2proc_tag = (hit & ~own) ? mem2proc_tag : '0;
  assign Ctlr2proc_data = (hit & ~own) ? mem2proc_data : '0;
  assign Ctlr2icache_tag = (hit & own) ? mem2proc_tag : '0;
  assign Ctlr2icache_data = (hit & own) ? mem2proc_data : '0;
  assign dcache_outstanding = d_cnt_q;
  assign icache_outstanding = i_cnt_q;
  assign ctlr_err = err_q;
  always_comb begin
    valid_d = valid_q;
    owner_d = owner_q;
    if (hit) valid_d[mem2proc_tag] = 1'b0;
    if (alloc) begin
      valid_d[mem2proc_response] = 1'b1;
      owner_d[mem2proc_response] = gnt_i;
    end
  end
  assign d_cnt_d = d_cnt_q + TAG_W'(alloc & ~gnt_i) - TAG_W'(hit & ~own)
                 - TAG_W'(ovr & ~owner_q[mem2proc_response]);
  assign i_cnt_d = i_cnt_q + TAG_W'(alloc & gnt_i) - TAG_W'(hit & own)
                 - TAG_W'(ovr & owner_q[mem2proc_response]);
  assign err_d = err_q | ovr;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      valid_q <= '0;
      owner_q <= '0;
      d_cnt_q <= '0;
      i_cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
      d_cnt_q <= d_cnt_d;
      i_cnt_q <= i_cnt_d;
      err_q <= err_d;
    end
endmodule

// File: tb/tb_mem_ctlr.sv
// tb_mem_ctlr: directed vector table, async-reset sequence and randomized run against a tag-ownership model.
`ifndef XLEN
`define XLEN 32
`endif
module tb_mem_ctlr;
  localparam int TW = 4;
`ifdef MEM_CTLR_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b0;
  logic [1:0] dcache2ctlr_command, icache2ctlr_command, proc2mem_command;
  logic [`XLEN-1:0] dcache2ctlr_addr, icache2ctlr_addr, proc2mem_addr;
  logic [63:0] dcache2ctlr_data, proc2mem_data, mem2proc_data, Ctlr2proc_data, Ctlr2icache_data;
  logic [TW-1:0] mem2proc_response, mem2proc_tag, Ctlr2proc_response, Ctlr2proc_tag;
  logic [TW-1:0] Ctlr2icache_response, Ctlr2icache_tag, dcache_outstanding, icache_outstanding;
  logic ctlr_err;
  always #5 clock = ~clock;
  mem_ctlr #(.TAG_W(TW)) dut (
    .clock(clock), .reset(reset),
    .dcache2ctlr_command(dcache2ctlr_command), .dcache2ctlr_addr(dcache2ctlr_addr),
    .dcache2ctlr_data(dcache2ctlr_data), .icache2ctlr_command(icache2ctlr_command),
    .icache2ctlr_addr(icache2ctlr_addr), .proc2mem_command(proc2mem_command),
    .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag), .Ctlr2proc_response(Ctlr2proc_response),
    .Ctlr2proc_data(Ctlr2proc_data), .Ctlr2proc_tag(Ctlr2proc_tag),
    .Ctlr2icache_response(Ctlr2icache_response), .Ctlr2icache_data(Ctlr2icache_data),
    .Ctlr2icache_tag(Ctlr2icache_tag), .dcache_outstanding(dcache_outstanding),
    .icache_outstanding(icache_outstanding), .ctlr_err(ctlr_err)
  );
  typedef struct {
    logic [1:0] dc, ic, pc;
    logic [3:0] rsp, tg, dr, ir, dt, it, dn, inn;
    logic [63:0] rd, dd, id;
    logic er;
  } vec_t;
  vec_t tbl[21];
  int n_vec = 0, n_bad = 0;
  int own_m[16];
  int last_m;
  bit err_m;
  function automatic vec_t mk(int dc, int ic, int rsp, int tg, int rd, int pc, int dr, int ir,
                              int dt, int dd, int it, int id, int dn, int inn, int er);
    vec_t v;
    v.dc = 2'(dc); v.ic = 2'(ic); v.rsp = 4'(rsp); v.tg = 4'(tg); v.rd = 64'(rd);
    v.pc = 2'(pc); v.dr = 4'(dr); v.ir = 4'(ir); v.dt = 4'(dt); v.dd = 64'(dd);
    v.it = 4'(it); v.id = 64'(id); v.dn = 4'(dn); v.inn = 4'(inn); v.er = er[0];
    return v;
  endfunction
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %0h expected %0h", nm, n_vec, got, exp);
    end
  endtask
  task automatic idle();
    dcache2ctlr_command = 2'd0; icache2ctlr_command = 2'd0;
    dcache2ctlr_addr = '0; icache2ctlr_addr = '0; dcache2ctlr_data = '0;
    mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
  endtask
  initial begin
    tbl[0]  = mk(0,0,0,0,0,         0,0,0,0,0,0,0,0,0,0);
    tbl[1]  = mk(1,0,3,0,0,         1,3,0,0,0,0,0,0,0,0);
    tbl[2]  = mk(0,0,0,0,0,         0,0,0,0,0,0,0,1,0,0);
    tbl[3]  = mk(0,0,0,3,'hDEAD,    0,0,0,3,'hDEAD,0,0,1,0,0);
    tbl[4]  = mk(0,0,0,0,0,         0,0,0,0,0,0,0,0,0,0);
    tbl[5]  = mk(2,1,1,0,0,         RR?1:2,RR?0:1,RR?1:0,0,0,0,0,0,0,0);
    tbl[6]  = mk(2,1,2,0,0,         2,2,0,0,0,0,0,RR?0:1,RR?1:0,0);
    tbl[7]  = mk(2,1,3,0,0,         RR?1:2,RR?0:3,RR?3:0,0,0,0,0,RR?1:2,RR?1:0,0);
    tbl[8]  = mk(2,1,0,0,0,         2,0,0,0,0,0,0,RR?1:3,RR?2:0,0);
    tbl[9]  = mk(2,1,0,0,0,         2,0,0,0,0,0,0,RR?1:3,RR?2:0,0);
    tbl[10] = mk(2,1,4,0,0,         2,4,0,0,0,0,0,RR?1:3,RR?2:0,0);
    tbl[11] = mk(0,0,0,0,0,         0,0,0,0,0,0,0,RR?2:4,RR?2:0,0);
    tbl[12] = mk(1,0,5,0,0,         1,5,0,0,0,0,0,RR?2:4,RR?2:0,0);
    tbl[13] = mk(0,1,5,5,'h55,      1,0,5,5,'h55,0,0,RR?3:5,RR?2:0,0);
    tbl[14] = mk(0,0,0,0,0,         0,0,0,0,0,0,0,RR?2:4,RR?3:1,0);
    tbl[15] = mk(0,0,0,5,'h66,      0,0,0,0,0,5,'h66,RR?2:4,RR?3:1,0);
    tbl[16] = mk(0,0,0,0,0,         0,0,0,0,0,0,0,RR?2:4,RR?2:0,0);
    tbl[17] = mk(1,0,7,0,0,         1,7,0,0,0,0,0,RR?2:4,RR?2:0,0);
    tbl[18] = mk(1,0,7,0,0,         1,7,0,0,0,0,0,RR?3:5,RR?2:0,0);
    tbl[19] = mk(0,0,0,0,0,         0,0,0,0,0,0,0,RR?3:5,RR?2:0,1);
    tbl[20] = mk(0,0,0,0,0,         0,0,0,0,0,0,0,RR?3:5,RR?2:0,1);
    idle();
    #12 reset = 1'b1;
    for (int i = 0; i < 21; i++) begin
      @(posedge clock); #1;
      dcache2ctlr_command = tbl[i].dc; icache2ctlr_command = tbl[i].ic;
      dcache2ctlr_addr = `XLEN'('h100); icache2ctlr_addr = `XLEN'('h200);
      dcache2ctlr_data = 64'h1234;
      mem2proc_response = tbl[i].rsp; mem2proc_tag = tbl[i].tg; mem2proc_data = tbl[i].rd;
      @(negedge clock);
      n_vec++;
      chk("pcmd", 64'(proc2mem_command), 64'(tbl[i].pc));
      chk("dresp", 64'(Ctlr2proc_response), 64'(tbl[i].dr));
      chk("iresp", 64'(Ctlr2icache_response), 64'(tbl[i].ir));
      chk("dtag", 64'(Ctlr2proc_tag), 64'(tbl[i].dt));
      chk("ddata", Ctlr2proc_data, tbl[i].dd);
      chk("itag", 64'(Ctlr2icache_tag), 64'(tbl[i].it));
      chk("idata", Ctlr2icache_data, tbl[i].id);
      chk("dout", 64'(dcache_outstanding), 64'(tbl[i].dn));
      chk("iout", 64'(icache_outstanding), 64'(tbl[i].inn));
      chk("err", 64'(ctlr_err), 64'(tbl[i].er));
    end
    // asynchronous reset mid-cycle with tags outstanding and the error flag set
    @(posedge clock); #1;
    dcache2ctlr_command = 2'd1; dcache2ctlr_addr = `XLEN'('h300); mem2proc_response = 4'd3;
    #2 reset = 1'b0;
    #1 n_vec++;
    chk("rst_dout", 64'(dcache_outstanding), 64'd0);
    chk("rst_iout", 64'(icache_outstanding), 64'd0);
    chk("rst_err", 64'(ctlr_err), 64'd0);
    chk("rst_dresp", 64'(Ctlr2proc_response), 64'd3);
    chk("rst_paddr", 64'(proc2mem_addr), 64'h300);
    idle();
    mem2proc_tag = 4'd1; mem2proc_data = 64'hBEEF;
    #1 chk("rst_dtag", 64'(Ctlr2proc_tag), 64'd0);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    mem2proc_tag = 4'd1; mem2proc_data = 64'hBEEF;
    @(negedge clock); n_vec++;
    chk("post_dtag", 64'(Ctlr2proc_tag), 64'd0);
    chk("post_itag", 64'(Ctlr2icache_tag), 64'd0);
    chk("post_ddata", Ctlr2proc_data, 64'd0);
    chk("post_dout", 64'(dcache_outstanding), 64'd0);
    idle();
    for (int i = 0; i < 16; i++) own_m[i] = -1;
    last_m = 1; err_m = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      logic dq, iq, gi, g, h, o;
      logic [`XLEN-1:0] ea;
      int dn, inn;
      @(posedge clock); #1;
      dcache2ctlr_command = 2'($urandom_range(0, 2));
      icache2ctlr_command = 2'($urandom_range(0, 1));
      dcache2ctlr_addr = `XLEN'({$urandom, $urandom}) & ~`XLEN'(7);
      icache2ctlr_addr = `XLEN'({$urandom, $urandom});
      dcache2ctlr_data = {$urandom, $urandom};
      mem2proc_response = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      mem2proc_tag = 4'($urandom_range(0, 15));
      mem2proc_data = {$urandom, $urandom};
      @(negedge clock); n_vec++;
      dq = dcache2ctlr_command != 2'd0;
      iq = icache2ctlr_command != 2'd0;
      gi = iq && (!dq || (RR && last_m == 0));
      g = dq || iq;
      ea = gi ? icache2ctlr_addr : dq ? dcache2ctlr_addr : '0;
      h = mem2proc_tag != 0 && own_m[mem2proc_tag] >= 0;
      o = own_m[mem2proc_tag] == 1;
      dn = 0; inn = 0;
      for (int j = 0; j < 16; j++) begin
        if (own_m[j] == 0) dn++;
        if (own_m[j] == 1) inn++;
      end
      chk("r_pcmd", 64'(proc2mem_command), 64'(gi ? icache2ctlr_command : dq ? dcache2ctlr_command : 2'd0));
      chk("r_paddr", 64'(proc2mem_addr), 64'(ea));
      chk("r_pdata", proc2mem_data, (dq && !gi) ? dcache2ctlr_data : 64'd0);
      chk("r_dresp", 64'(Ctlr2proc_response), 64'((g && !gi) ? mem2proc_response : 4'd0));
      chk("r_iresp", 64'(Ctlr2icache_response), 64'(gi ? mem2proc_response : 4'd0));
      chk("r_dtag", 64'(Ctlr2proc_tag), 64'((h && !o) ? mem2proc_tag : 4'd0));
      chk("r_ddata", Ctlr2proc_data, (h && !o) ? mem2proc_data : 64'd0);
      chk("r_itag", 64'(Ctlr2icache_tag), 64'((h && o) ? mem2proc_tag : 4'd0));
      chk("r_idata", Ctlr2icache_data, (h && o) ? mem2proc_data : 64'd0);
      chk("r_dout", 64'(dcache_outstanding), 64'(dn));
      chk("r_iout", 64'(icache_outstanding), 64'(inn));
      chk("r_err", 64'(ctlr_err), 64'(err_m));
      if (h) own_m[mem2proc_tag] = -1;
      if (mem2proc_response != 0 && g) begin
        if (own_m[mem2proc_response] >= 0) err_m = 1'b1;
        own_m[mem2proc_response] = gi ? 1 : 0;
        last_m = gi ? 1 : 0;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_ctlr.md
# mem_ctlr

Memory-bus arbiter directly downstream of the data cache's miss-handling queue and the instruction cache. Each cycle it grants the single memory port to one requester and returns the memory's accept tag to that requester in the same cycle. It records which requester owns each outstanding tag and steers each returning tag and its data to the owner only.

## Interface
Parameters:
- `TAG_W`, default 4: memory tag width. Valid tags are 1..2^TAG_W-1; tag 0 means "none".

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `dcache2ctlr_command`  in  2  BUS_NONE / BUS_LOAD / BUS_STORE from dcache.
- `dcache2ctlr_addr`  in  `XLEN`  dcache request address, 8-byte aligned.
- `dcache2ctlr_data`  in  64  dcache store data.
- `icache2ctlr_command`  in  2  BUS_NONE / BUS_LOAD from icache.
- `icache2ctlr_addr`  in  `XLEN`  icache request address.
- `proc2mem_command`  out  2  command to memory.
- `proc2mem_addr`  out  `XLEN`  address to memory.
- `proc2mem_data`  out  64  store data to memory.
- `mem2proc_response`  in  TAG_W  accept tag from memory; 0 means rejected.
- `mem2proc_data`  in  64  returning data.
- `mem2proc_tag`  in  TAG_W  completing tag; 0 means none.
- `Ctlr2proc_response`, `Ctlr2proc_data`, `Ctlr2proc_tag`  out  TAG_W / 64 / TAG_W  dcache side of the response and return path.
- `Ctlr2icache_response`, `Ctlr2icache_data`, `Ctlr2icache_tag`  out  TAG_W / 64 / TAG_W  icache side of the response and return path.
- `dcache_outstanding`  out  TAG_W  count of valid tags owned by dcache.
- `icache_outstanding`  out  TAG_W  count of valid tags owned by icache.
- `ctlr_err`  out  1  sticky error: memory accepted a tag that is already outstanding.

## Operation
- A requester is "requesting" when its command is not BUS_NONE.
- Grant is combinational:
  - Only one requester requesting: that requester is granted.
  - Both requesting: resolved by the arbitration policy (see Configuration).
  - Neither requesting: `proc2mem_command` = BUS_NONE and `proc2mem_addr`/`proc2mem_data` = 0.
- Memory port outputs carry the granted requester's command, address and data. For an icache grant, `proc2mem_data` = 0.
- Accept response: `mem2proc_response` goes unchanged to the granted requester's `*_response` port. The non-granted requester sees 0.
- Tag table: 2^TAG_W entries, each {valid, owner}.
  - On a clock edge where `mem2proc_response` ≠ 0 and a grant exists, entry[response] becomes valid with owner = granted requester.
  - If entry[response] was already valid at that edge, `ctlr_err` is set (sticky until reset) and the entry is overwritten.
- Return path, combinational:
  - If `mem2proc_tag` ≠ 0 and entry[tag] is valid, the owner's `*_tag` and `*_data` ports carry `mem2proc_tag` and `mem2proc_data`. The other requester's ports are 0. The entry is cleared at the next edge.
  - If the tag is 0 or entry[tag] is invalid, both return ports are 0 and the return is dropped silently.
- Same-tag collision: a tag that both returns and is re-accepted in the same cycle is forwarded to its old owner. The clear is then overridden by the new allocation (set wins), and `ctlr_err` is not raised.
- Outstanding counters:
  - A counter increments on allocation and decrements on clear.
  - Both on the same edge for the same owner: the counter is unchanged.
  - An overwrite on error moves the count from the old owner to the new owner.
- Entry 0 is never allocated.

## Timing
- All grant, response and return paths are zero-latency combinational. A requester sees its tag in the same cycle its command is presented.
- Tag table, counters, the arbitration pointer and `ctlr_err` update on the rising edge.
- A tag accepted in cycle N can be returned and forwarded no earlier than cycle N+1.
- Reset (asynchronous, `reset`=0, also mid-operation):
  - All table entries invalid; both counters 0; `ctlr_err` 0; arbitration pointer favours dcache.
  - Tags returned after reset for pre-reset requests are dropped.
  - Combinational outputs follow their inputs while in reset, except the return ports, which are 0 because the table is empty.

## Configuration
- `MEM_CTLR_RR_EN`:
  - Defined: round-robin arbitration. A one-bit pointer names the last accepted requester. On a conflict the other requester wins. The pointer updates only on an edge where `mem2proc_response` ≠ 0.
  - Undefined: fixed priority, dcache always wins conflicts and no pointer is instantiated.

## Test plan
- dcache BUS_LOAD at 0x100, icache idle, `mem2proc_response`=3 → `Ctlr2proc_response`=3, `Ctlr2icache_response`=0. Next cycle `dcache_outstanding`=1. Later `mem2proc_tag`=3 with data 0xDEAD → `Ctlr2proc_tag`=3 and data 0xDEAD, icache return ports 0; `dcache_outstanding` returns to 0.
- Both requesting for 3 accepted cycles (responses 1, 2, 3) → RR build grants icache, dcache, icache; fixed build grants dcache three times and icache sees response 0.
- Both requesting with `mem2proc_response`=0 for 2 cycles → no table change and RR pointer unchanged; the next accepted grant matches the pre-stall pointer.
- Tag 5 returns while memory re-accepts tag 5 for icache in the same cycle (old owner dcache) → dcache receives the return; entry 5 becomes valid with owner icache; `ctlr_err` stays 0.
- Memory accepts tag 7 twice without a return in between → `ctlr_err`=1 after the second edge and stays 1 until reset.
- Two dcache tags outstanding, assert `reset`=0 asynchronously mid-cycle → counters and `ctlr_err` 0 immediately. After release, `mem2proc_tag`=1 returns → both return ports 0.
